ex_pipe_chain: RTL and testbench

- Parametrised chain of DEPTH execute-stage pipeline registers, replacing the hand-written per-stage EX registers of the SAD datapath.
- Each stage has a valid bit, a data payload, a control word, a destination register number and a register-write flag.
- Adds stall (hold), per-stage kill/flush, bubble insertion, hazard taps and a retire counter.
- Sits between the EX1 input mux and the MEM stage register.

---
 rtl/ex_pipe_pkg.sv | 34 +++
 rtl/ex_stage_reg.sv | 47 ++++
 rtl/ex_pipe_chain.sv | 105 ++++++++++
 tb/tb_ex_pipe_chain.sv | 413 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ex_pipe_pkg.sv
// ============================================================================
//  Module      : ex_pipe_pkg
//  Description : Shared constants and the bubble value for the EX stage chain.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ex_pipe_pkg;

    localparam int DEF_DEPTH  = 7;
    localparam int DEF_DATA_W = 512;
    localparam int DEF_CTRL_W = 12;
    localparam int DEF_DST_W  = 5;
    localparam int DEF_CNT_W  = 32;

    // Control word bit positions
    localparam int MEMWRITE_LSB = 0;
    localparam int MEMREAD_LSB  = 1;
    localparam int MEMTOREG     = 2;
    localparam int JAL          = 3;
    localparam int JUMP         = 4;
    localparam int JR           = 5;
    localparam int SAD          = 6;

    localparam int MAX_ENTRY_W = 2048;

    // A bubble is all-zero: valid, payload, control, destination and write flag.
    function automatic logic [MAX_ENTRY_W-1:0] bubble_entry();
        return '0;
    endfunction

endpackage

`default_nettype wire

// File: rtl/ex_stage_reg.sv
// ============================================================================
//  Module      : ex_stage_reg
//  Description : One EX pipeline stage register with hold and clear-to-bubble.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ex_stage_reg #(
    parameter int ENTRY_W = 531
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic               hold,
    input  logic               clear,
    input  logic [ENTRY_W-1:0] d_entry,
    output logic [ENTRY_W-1:0] q_entry
);
    import ex_pipe_pkg::*;

    localparam logic [ENTRY_W-1:0] c_bubble = ENTRY_W'(bubble_entry());

    logic [ENTRY_W-1:0] entry_q;
    logic [ENTRY_W-1:0] entry_d;

    // Clear wins over hold so a stalled slot can still be flushed in place.
    always_comb begin
        entry_d = entry_q;
        if (clear) begin
            entry_d = c_bubble;
        end else if (!hold) begin
            entry_d = d_entry;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            entry_q <= '0;
        end else begin
            entry_q <= entry_d;
        end
    end

    assign q_entry = entry_q;

endmodule

`default_nettype wire

// File: rtl/ex_pipe_chain.sv
// ============================================================================
//  Module      : ex_pipe_chain
//  Description : DEPTH-stage EX register chain with stall, kill, hazard taps,
//                occupancy and retire counter.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ex_pipe_chain
    import ex_pipe_pkg::*;
#(
    parameter int DEPTH  = DEF_DEPTH,
    parameter int DATA_W = DEF_DATA_W,
    parameter int CTRL_W = DEF_CTRL_W,
    parameter int DST_W  = DEF_DST_W,
    parameter int CNT_W  = DEF_CNT_W
) (
    input  logic                         Clk,
    input  logic                         Reset,
    input  logic                         stall,
    input  logic [DEPTH:0]               kill,
    input  logic                         in_valid,
    input  logic [DATA_W-1:0]            in_data,
    input  logic [CTRL_W-1:0]            in_ctrl,
    input  logic [DST_W-1:0]             in_dst,
    input  logic                         in_wr,
    output logic                         out_valid,
    output logic [DATA_W-1:0]            out_data,
    output logic [CTRL_W-1:0]            out_ctrl,
    output logic [DST_W-1:0]             out_dst,
    output logic                         out_wr,
    output logic [DEPTH-1:0]             tap_valid,
    output logic [DEPTH*DST_W-1:0]       tap_dst,
    output logic [DEPTH-1:0]             tap_wr,
    output logic [$clog2(DEPTH+1)-1:0]   occupancy,
    output logic                         busy,
    output logic [CNT_W-1:0]             retired
);

    localparam int c_entry_w = DATA_W + CTRL_W + DST_W + 2;
    localparam int c_occ_w   = $clog2(DEPTH+1);
    localparam logic [c_entry_w-1:0] c_bubble = c_entry_w'(bubble_entry());

    logic [c_entry_w-1:0] in_entry;
    logic [c_entry_w-1:0] stage_d [DEPTH];
    logic [c_entry_w-1:0] stage_q [DEPTH];
    logic [c_occ_w-1:0]   occ_sum;
    logic [CNT_W-1:0]     retired_q;
    logic [CNT_W-1:0]     retired_d;

    // An invalid input never carries its payload or control into the chain.
    assign in_entry = in_valid ? {1'b1, in_data, in_ctrl, in_dst, in_wr} : c_bubble;

    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        if (i == 0) begin : g_head
            assign stage_d[i] = in_entry;
        end else begin : g_body
            assign stage_d[i] = stage_q[i-1];
        end

        // Advancing: kill[i] flushes what moves into stage i.
        // Stalled:   kill[i+1] flushes what sits in stage i.
        ex_stage_reg #(
            .ENTRY_W (c_entry_w)
        ) u_stage (
            .Clk     (Clk),
            .Reset   (Reset),
            .hold    (stall),
            .clear   (stall ? kill[i+1] : kill[i]),
            .d_entry (stage_d[i]),
            .q_entry (stage_q[i])
        );

        assign tap_valid[i]               = stage_q[i][c_entry_w-1];
        assign tap_dst[i*DST_W +: DST_W]  = stage_q[i][DST_W:1];
        assign tap_wr[i]                  = stage_q[i][c_entry_w-1] & stage_q[i][0];
    end

    assign {out_valid, out_data, out_ctrl, out_dst, out_wr} = stage_q[DEPTH-1];

    always_comb begin
        occ_sum = '0;
        for (int i = 0; i < DEPTH; i++) begin
            occ_sum = occ_sum + c_occ_w'(tap_valid[i]);
        end
    end

    assign occupancy = occ_sum;
    assign busy      = (occ_sum != '0);

    assign retired_d = retired_q + CNT_W'(1);

    always_ff @(posedge Clk) begin
        if (Reset) begin
            retired_q <= '0;
        end else if (!stall && out_valid) begin
            retired_q <= retired_d;
        end
    end

    assign retired = retired_q;

endmodule

`default_nettype wire

// File: tb/tb_ex_pipe_chain.sv
// ============================================================================
//  Module      : tb_ex_pipe_chain
//  Description : Self-checking bench for ex_pipe_chain (DEPTH 7, 1 and 12).
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_ex_pipe_chain;

    localparam int D  = 7;
    localparam int DW = 512;
    localparam int CW = 12;
    localparam int SW = 5;
    localparam int NW = 32;

    logic Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Main DUT (default geometry)
    logic          Reset, stall, in_valid, in_wr;
    logic [D:0]    kill;
    logic [DW-1:0] in_data;
    logic [CW-1:0] in_ctrl;
    logic [SW-1:0] in_dst;
    logic          out_valid, out_wr, busy;
    logic [DW-1:0] out_data;
    logic [CW-1:0] out_ctrl;
    logic [SW-1:0] out_dst;
    logic [D-1:0]  tap_valid, tap_wr;
    logic [D*SW-1:0] tap_dst;
    logic [2:0]    occupancy;
    logic [NW-1:0] retired;

    ex_pipe_chain #(.DEPTH(D), .DATA_W(DW), .CTRL_W(CW), .DST_W(SW), .CNT_W(NW)) dut (
        .Clk(Clk), .Reset(Reset), .stall(stall), .kill(kill), .in_valid(in_valid),
        .in_data(in_data), .in_ctrl(in_ctrl), .in_dst(in_dst), .in_wr(in_wr),
        .out_valid(out_valid), .out_data(out_data), .out_ctrl(out_ctrl), .out_dst(out_dst),
        .out_wr(out_wr), .tap_valid(tap_valid), .tap_dst(tap_dst), .tap_wr(tap_wr),
        .occupancy(occupancy), .busy(busy), .retired(retired)
    );

    // DEPTH=1 variant
    logic        s1_stall, s1_valid, s1_out_valid, s1_out_wr, s1_busy;
    logic [1:0]  s1_kill;
    logic [31:0] s1_data, s1_out_data, s1_ret;
    logic [CW-1:0] s1_out_ctrl;
    logic [SW-1:0] s1_out_dst, s1_tap_dst;
    logic [0:0]  s1_tap_valid, s1_tap_wr, s1_occ;

    ex_pipe_chain #(.DEPTH(1), .DATA_W(32), .CTRL_W(CW), .DST_W(SW), .CNT_W(NW)) dut_d1 (
        .Clk(Clk), .Reset(Reset), .stall(s1_stall), .kill(s1_kill), .in_valid(s1_valid),
        .in_data(s1_data), .in_ctrl(in_ctrl), .in_dst(in_dst), .in_wr(in_wr),
        .out_valid(s1_out_valid), .out_data(s1_out_data), .out_ctrl(s1_out_ctrl),
        .out_dst(s1_out_dst), .out_wr(s1_out_wr), .tap_valid(s1_tap_valid), .tap_dst(s1_tap_dst),
        .tap_wr(s1_tap_wr), .occupancy(s1_occ), .busy(s1_busy), .retired(s1_ret)
    );

    // DEPTH=12 variant
    logic        s12_stall, s12_valid, s12_out_valid, s12_out_wr, s12_busy;
    logic [12:0] s12_kill;
    logic [31:0] s12_data, s12_out_data, s12_ret;
    logic [CW-1:0] s12_out_ctrl;
    logic [SW-1:0] s12_out_dst;
    logic [12*SW-1:0] s12_tap_dst;
    logic [11:0] s12_tap_valid, s12_tap_wr;
    logic [3:0]  s12_occ;

    ex_pipe_chain #(.DEPTH(12), .DATA_W(32), .CTRL_W(CW), .DST_W(SW), .CNT_W(NW)) dut_d12 (
        .Clk(Clk), .Reset(Reset), .stall(s12_stall), .kill(s12_kill), .in_valid(s12_valid),
        .in_data(s12_data), .in_ctrl(in_ctrl), .in_dst(in_dst), .in_wr(in_wr),
        .out_valid(s12_out_valid), .out_data(s12_out_data), .out_ctrl(s12_out_ctrl),
        .out_dst(s12_out_dst), .out_wr(s12_out_wr), .tap_valid(s12_tap_valid), .tap_dst(s12_tap_dst),
        .tap_wr(s12_tap_wr), .occupancy(s12_occ), .busy(s12_busy), .retired(s12_ret)
    );

    // Reference model of the main chain: one slot per stage, youngest at index 0.
    typedef struct packed {
        logic          v;
        logic [DW-1:0] d;
        logic [CW-1:0] c;
        logic [SW-1:0] dst;
        logic          w;
    } ent_t;

    ent_t          m [D];
    logic [NW-1:0] m_ret;
    int            n_checks = 0;
    int            n_fail   = 0;

    function automatic int m_occ();
        int n = 0;
        for (int j = 0; j < D; j++) n += int'(m[j].v);
        return n;
    endfunction

    // Advance the model by one clock from the currently driven inputs, then clock the DUTs.
    task automatic step();
        ent_t nx [D];
        if (Reset) begin
            for (int j = 0; j < D; j++) m[j] = '0;
            m_ret = '0;
        end else begin
            if (!stall && m[D-1].v) m_ret = m_ret + 1;
            for (int j = 0; j < D; j++) nx[j] = m[j];
            if (stall) begin
                for (int j = 0; j < D; j++) if (kill[j+1]) nx[j] = '0;
            end else begin
                nx[0] = (kill[0] || !in_valid) ? '0 : {1'b1, in_data, in_ctrl, in_dst, in_wr};
                for (int j = 1; j < D; j++) nx[j] = kill[j] ? '0 : m[j-1];
            end
            for (int j = 0; j < D; j++) m[j] = nx[j];
        end
        @(posedge Clk);
        #1;
    endtask

    task automatic idle();
        stall = 1'b0; kill = '0; in_valid = 1'b0; in_data = '0;
        in_ctrl = '0; in_dst = '0; in_wr = 1'b0;
        s1_stall = 1'b0; s1_kill = '0; s1_valid = 1'b0; s1_data = '0;
        s12_stall = 1'b0; s12_kill = '0; s12_valid = 1'b0; s12_data = '0;
    endtask

    // Leaves stage j holding value j+1 (stage D-1 holds D).
    task automatic fill_desc();
        for (int k = D; k >= 1; k--) begin
            in_valid = 1'b1; in_data = DW'(k); in_ctrl = CW'(k); in_dst = SW'(k); in_wr = 1'b1;
            step();
        end
        idle();
    endtask

    task automatic test_reset();
        idle();
        Reset = 1'b1; in_valid = 1'b1; in_data = DW'($urandom); in_wr = 1'b1;
        step(); step();
        Reset = 1'b0; idle();
        n_checks++;
        if ({out_valid, out_data, out_ctrl, out_dst, out_wr} !== '0) begin
            n_fail++; $display("FAIL reset_out: got valid=%0b data=%0h ctrl=%0h want all 0", out_valid, out_data, out_ctrl);
        end
        n_checks++;
        if ({tap_valid, tap_wr, tap_dst} !== '0) begin
            n_fail++; $display("FAIL reset_taps: got valid=%0h wr=%0h dst=%0h want 0", tap_valid, tap_wr, tap_dst);
        end
        n_checks++;
        if (retired !== '0 || occupancy !== '0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL reset_counters: got retired=%0d occ=%0d busy=%0b want 0", retired, occupancy, busy);
        end
    endtask

    task automatic test_stream();
        int ev;
        for (int t = 1; t <= 20; t++) begin
            if (t <= 10) begin
                in_valid = 1'b1; in_data = DW'(t); in_ctrl = CW'(t); in_dst = SW'(t % 32); in_wr = 1'b1;
            end else begin
                idle();
            end
            step();
            ev = (t >= 7 && t <= 16) ? 1 : 0;
            n_checks++;
            if (out_valid !== ev[0] || out_data !== (ev != 0 ? DW'(t-6) : DW'(0))) begin
                n_fail++; $display("FAIL stream_out t=%0d: got valid=%0b data=%0d want valid=%0d data=%0d",
                                   t, out_valid, out_data, ev, (ev != 0) ? t-6 : 0);
            end
        end
        n_checks++;
        if (retired !== 32'd10) begin
            n_fail++; $display("FAIL stream_retired: got %0d want 10", retired);
        end
        n_checks++;
        if (busy !== 1'b0 || occupancy !== 3'd0) begin
            n_fail++; $display("FAIL stream_drain: got busy=%0b occ=%0d want 0/0", busy, occupancy);
        end
    endtask

    task automatic test_stall_hold();
        logic [NW-1:0]   r0;
        logic [D*SW-1:0] dst0;
        int              seen;
        fill_desc();
        r0 = retired; dst0 = tap_dst;
        stall = 1'b1; in_valid = 1'b1; in_data = DW'(99); in_dst = 5'd31; in_wr = 1'b1;
        for (int c = 0; c < 3; c++) begin
            step();
            n_checks++;
            if (out_data !== DW'(7) || tap_dst !== dst0 || retired !== r0) begin
                n_fail++; $display("FAIL stall_hold c=%0d: got data=%0d dst=%0h ret=%0d want 7 %0h %0d",
                                   c, out_data, tap_dst, retired, dst0, r0);
            end
        end
        stall = 1'b0; in_valid = 1'b0;
        step();
        n_checks++;
        if (out_data !== DW'(6) || retired !== r0 + 1 || tap_valid[0] !== 1'b0) begin
            n_fail++; $display("FAIL stall_release: got data=%0d ret=%0d tv0=%0b want 6 %0d 0",
                               out_data, retired, tap_valid[0], r0 + 1);
        end
        in_valid = 1'b1;
        step();
        n_checks++;
        if (tap_valid[0] !== 1'b1 || tap_dst[SW-1:0] !== 5'd31) begin
            n_fail++; $display("FAIL stall_capture99: got tv0=%0b dst0=%0d want 1 31", tap_valid[0], tap_dst[SW-1:0]);
        end
        idle();
        seen = 0;
        for (int c = 0; c < 8; c++) begin
            step();
            if (out_valid && out_data == DW'(99)) seen++;
        end
        n_checks++;
        if (seen != 1) begin
            n_fail++; $display("FAIL stall_99_once: got %0d appearances want 1", seen);
        end
    endtask

    task automatic test_kill_advance();
        logic [NW-1:0] rb;
        logic [2:0]    occ0;
        fill_desc();
        rb = retired; occ0 = occupancy;
        kill = 8'b0000_1000; in_valid = 1'b1; in_data = DW'(8); in_ctrl = CW'(8); in_dst = 5'd8; in_wr = 1'b1;
        step();
        kill = '0;
        n_checks++;
        if (tap_valid[3] !== 1'b0 || tap_wr[3] !== 1'b0 || tap_dst[3*SW +: SW] !== '0) begin
            n_fail++; $display("FAIL kill_adv_stage3: got v=%0b w=%0b dst=%0d want 0", tap_valid[3], tap_wr[3], tap_dst[3*SW +: SW]);
        end
        n_checks++;
        if (occupancy !== occ0 - 3'd1) begin
            n_fail++; $display("FAIL kill_adv_occ: got %0d want %0d", occupancy, occ0 - 3'd1);
        end
        for (int c = 9; c <= 11; c++) begin
            in_data = DW'(c); in_ctrl = CW'(c); in_dst = SW'(c);
            step();
        end
        n_checks++;
        if ({out_valid, out_data, out_ctrl, out_dst, out_wr} !== '0) begin
            n_fail++; $display("FAIL kill_adv_bubble_out: got v=%0b data=%0d ctrl=%0h wr=%0b want 0", out_valid, out_data, out_ctrl, out_wr);
        end
        n_checks++;
        if (retired !== rb + 4) begin
            n_fail++; $display("FAIL kill_adv_retired4: got %0d want %0d", retired, rb + 4);
        end
        step();
        n_checks++;
        if (retired !== rb + 4 || out_data !== DW'(2)) begin
            n_fail++; $display("FAIL kill_adv_after: got ret=%0d data=%0d want %0d 2", retired, out_data, rb + 4);
        end
        idle();
        for (int c = 0; c < D; c++) step();
    endtask

    task automatic test_kill_stall();
        logic [NW-1:0] r0;
        fill_desc();
        r0 = retired;
        stall = 1'b1; kill = 8'b1000_0000;
        step();
        n_checks++;
        if (out_valid !== 1'b0 || out_data !== '0 || out_ctrl !== '0) begin
            n_fail++; $display("FAIL kill_stall_last: got v=%0b data=%0d ctrl=%0h want 0", out_valid, out_data, out_ctrl);
        end
        n_checks++;
        if (tap_valid !== 7'b011_1111 || retired !== r0) begin
            n_fail++; $display("FAIL kill_stall_hold: got tv=%0b ret=%0d want 0111111 %0d", tap_valid, retired, r0);
        end
        idle();
        step();
        n_checks++;
        if (retired !== r0 || out_data !== DW'(6)) begin
            n_fail++; $display("FAIL kill_stall_release: got ret=%0d data=%0d want %0d 6", retired, out_data, r0);
        end
        for (int c = 0; c < D; c++) step();
    endtask

    task automatic test_reset_mid();
        Reset = 1'b1; step(); Reset = 1'b0;
        for (int t = 1; t <= 12; t++) begin
            in_valid = (t <= 3) || (t >= 6 && t <= 10);
            in_data = DW'(t); in_ctrl = CW'(t); in_dst = SW'(t); in_wr = 1'b1;
            step();
        end
        n_checks++;
        if (occupancy !== 3'd5 || retired !== 32'd3) begin
            n_fail++; $display("FAIL reset_mid_pre: got occ=%0d ret=%0d want 5 3", occupancy, retired);
        end
        Reset = 1'b1; in_valid = 1'b1; in_data = DW'(77);
        step();
        Reset = 1'b0; idle();
        n_checks++;
        if (tap_valid !== '0 || {out_valid, out_data, out_ctrl, out_dst, out_wr} !== '0 ||
            retired !== '0 || occupancy !== '0) begin
            n_fail++; $display("FAIL reset_mid_post: got tv=%0b ov=%0b ret=%0d occ=%0d want all 0",
                               tap_valid, out_valid, retired, occupancy);
        end
        step();
        n_checks++;
        if (tap_valid !== '0) begin
            n_fail++; $display("FAIL reset_mid_dropped: got tv=%0b want 0", tap_valid);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            Reset    = ($urandom_range(0, 99) == 0);
            stall    = ($urandom_range(0, 3) == 0);
            kill     = ($urandom_range(0, 4) == 0) ? (D+1)'($urandom & $urandom & $urandom) : '0;
            in_valid = ($urandom_range(0, 3) != 0);
            if (in_valid) begin
                for (int w = 0; w < DW/32; w++) in_data[w*32 +: 32] = $urandom;
                in_ctrl = CW'($urandom); in_dst = SW'($urandom); in_wr = 1'($urandom);
            end else begin
                in_data = 'x; in_ctrl = 'x; in_dst = 'x; in_wr = 1'bx;
            end
            step();
            n_checks++;
            if ({out_valid, out_data, out_ctrl, out_dst, out_wr} !== m[D-1]) begin
                n_fail++; $display("FAIL rand_out c=%0d: got v=%0b ctrl=%0h dst=%0d want v=%0b ctrl=%0h dst=%0d",
                                   c, out_valid, out_ctrl, out_dst, m[D-1].v, m[D-1].c, m[D-1].dst);
            end
            n_checks++;
            if (retired !== m_ret || int'(occupancy) != m_occ() || busy !== (m_occ() != 0)) begin
                n_fail++; $display("FAIL rand_counters c=%0d: got ret=%0d occ=%0d busy=%0b want %0d %0d",
                                   c, retired, occupancy, busy, m_ret, m_occ());
            end
            for (int j = 0; j < D; j++) begin
                n_checks++;
                if (tap_valid[j] !== m[j].v || tap_wr[j] !== (m[j].v & m[j].w) || tap_dst[j*SW +: SW] !== m[j].dst) begin
                    n_fail++; $display("FAIL rand_tap c=%0d s=%0d: got v=%0b w=%0b dst=%0d want %0b %0b %0d",
                                       c, j, tap_valid[j], tap_wr[j], tap_dst[j*SW +: SW], m[j].v, m[j].v & m[j].w, m[j].dst);
                end
            end
        end
        Reset = 1'b0; idle();
        for (int c = 0; c < D; c++) step();
    endtask

    task automatic test_sweep();
        int n;
        idle();
        Reset = 1'b1; step(); Reset = 1'b0;
        // Latency, DEPTH=1
        s1_valid = 1'b1; s1_data = 32'hA1; in_dst = 5'd3; in_wr = 1'b1;
        n = 0;
        do begin step(); n++; s1_valid = 1'b0; end while (!s1_out_valid && n < 30);
        n_checks++;
        if (n != 1 || s1_out_data !== 32'hA1 || s1_occ !== 1'b1) begin
            n_fail++; $display("FAIL sweep_d1_latency: got lat=%0d data=%0h occ=%0d want 1 a1 1", n, s1_out_data, s1_occ);
        end
        // Latency, DEPTH=12
        s12_valid = 1'b1; s12_data = 32'hB2;
        n = 0;
        do begin step(); n++; s12_valid = 1'b0; end while (!s12_out_valid && n < 30);
        n_checks++;
        if (n != 12 || s12_out_data !== 32'hB2) begin
            n_fail++; $display("FAIL sweep_d12_latency: got lat=%0d data=%0h want 12 b2", n, s12_out_data);
        end
        // Full occupancy for DEPTH=12
        for (int k = 1; k <= 12; k++) begin
            s12_valid = 1'b1; s12_data = 32'(k);
            step();
        end
        n_checks++;
        if (s12_occ !== 4'd12 || s12_busy !== 1'b1 || s12_tap_valid !== 12'hFFF) begin
            n_fail++; $display("FAIL sweep_d12_full: got occ=%0d busy=%0b tv=%0h want 12 1 fff", s12_occ, s12_busy, s12_tap_valid);
        end
        // kill[0] while advancing leaves stage0 empty
        s12_kill = 13'd1; s1_kill = 2'd1; s1_valid = 1'b1; s1_data = 32'hC3;
        step();
        n_checks++;
        if (s12_tap_valid[0] !== 1'b0 || s12_occ !== 4'd11 || s1_out_valid !== 1'b0 || s1_out_data !== '0) begin
            n_fail++; $display("FAIL sweep_kill0: got d12 tv0=%0b occ=%0d d1 v=%0b data=%0h want 0 11 0 0",
                               s12_tap_valid[0], s12_occ, s1_out_valid, s1_out_data);
        end
        // DEPTH=1: kill[1] ignored while advancing, honoured while stalled
        s12_kill = '0; s12_valid = 1'b0; s1_kill = 2'b10; s1_data = 32'hD4;
        step();
        n_checks++;
        if (s1_out_valid !== 1'b1 || s1_out_data !== 32'hD4) begin
            n_fail++; $display("FAIL sweep_d1_kill1_adv: got v=%0b data=%0h want 1 d4", s1_out_valid, s1_out_data);
        end
        s1_stall = 1'b1; s1_valid = 1'b0;
        step();
        n_checks++;
        if (s1_out_valid !== 1'b0 || s1_out_data !== '0 || s1_busy !== 1'b0) begin
            n_fail++; $display("FAIL sweep_d1_kill1_stall: got v=%0b data=%0h busy=%0b want 0 0 0", s1_out_valid, s1_out_data, s1_busy);
        end
        idle();
    endtask

    initial begin
        Reset = 1'b1;
        idle();
        for (int j = 0; j < D; j++) m[j] = '0;
        m_ret = '0;
        test_reset();
        test_stream();
        test_stall_hold();
        test_kill_advance();
        test_kill_stall();
        test_reset_mid();
        test_random();
        test_sweep();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
